cluster_clint: RTL and testbench

CLUSTER_CLINT -- requirements
Module: cluster_clint

---
 rtl/cluster_clint.sv | 164 ++++++++++++++++
 tb/tb_cluster_clint.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_clint.sv
// Cluster core-local interruptor: per-hart software interrupt bits, a shared
// 64-bit prescaled mtime counter and per-hart mtimecmp registers, accessed
// through a single-outstanding valid/ready register port.
module cluster_clint #(
  parameter int unsigned NrCores   = 8,
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned Prescaler = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NrCores-1:0]   msip_o,
  output logic [NrCores-1:0]   mtip_o
);

  localparam int unsigned   PsW   = (Prescaler > 1) ? $clog2(Prescaler) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(Prescaler - 1);

  // Architectural state
  logic [NrCores-1:0]        msip_q, msip_d;
  logic [NrCores-1:0][63:0]  mtimecmp_q, mtimecmp_d;
  logic [63:0]               mtime_q, mtime_d;
  logic [PsW-1:0]            ps_q, ps_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_error_q, rsp_error_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;

  // Decode signals
  logic [31:0] addr;
  logic [31:0] msip_hart;
  logic [31:0] cmp_hart;
  logic        sel_msip, sel_cmp, sel_mtime_lo, sel_mtime_hi, dec_err;
  logic [31:0] rdata;
  logic        accept, wr_en, tick;

  assign addr        = 32'(req_addr_i);
  assign req_ready_o = !rsp_valid_q;
  assign accept      = req_valid_i && !rsp_valid_q;
  assign wr_en       = accept && req_write_i && !dec_err;
  assign tick        = (ps_q == PsMax);

  // Address decode; anything not selecting a real register is an error
  always_comb begin
    msip_hart    = addr >> 2;
    cmp_hart     = (addr - 32'h4000) >> 3;
    sel_msip     = 1'b0;
    sel_cmp      = 1'b0;
    sel_mtime_lo = 1'b0;
    sel_mtime_hi = 1'b0;
    if (addr[1:0] == 2'b00) begin
      if (addr < 32'h4000) begin
        sel_msip = (msip_hart < 32'(NrCores));
      end else if (addr < 32'hBFF8) begin
        sel_cmp = (cmp_hart < 32'(NrCores));
      end else if (addr == 32'hBFF8) begin
        sel_mtime_lo = 1'b1;
      end else if (addr == 32'hBFFC) begin
        sel_mtime_hi = 1'b1;
      end
    end
    dec_err = !(sel_msip || sel_cmp || sel_mtime_lo || sel_mtime_hi);
  end

  // Read data mux from current register values
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      if (sel_msip && (msip_hart == 32'(i))) begin
        rdata = {31'd0, msip_q[i]};
      end
      if (sel_cmp && (cmp_hart == 32'(i))) begin
        rdata = addr[2] ? mtimecmp_q[i][63:32] : mtimecmp_q[i][31:0];
      end
    end
    if (sel_mtime_lo) rdata = mtime_q[31:0];
    if (sel_mtime_hi) rdata = mtime_q[63:32];
  end

  // Register writes for msip and mtimecmp halves
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    for (int unsigned i = 0; i < NrCores; i++) begin
      if (wr_en && sel_msip && (msip_hart == 32'(i))) begin
        msip_d[i] = req_wdata_i[0];
      end
      if (wr_en && sel_cmp && (cmp_hart == 32'(i))) begin
        if (addr[2]) mtimecmp_d[i][63:32] = req_wdata_i;
        else         mtimecmp_d[i][31:0]  = req_wdata_i;
      end
    end
  end

  // Prescaler and mtime; a software write to mtime wins over the tick
  always_comb begin
    ps_d    = tick ? '0 : ps_q + 1'b1;
    mtime_d = mtime_q;
    if (wr_en && sel_mtime_lo) begin
      mtime_d[31:0] = req_wdata_i;
    end else if (wr_en && sel_mtime_hi) begin
      mtime_d[63:32] = req_wdata_i;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // Response channel: capture at acceptance, hold until consumed
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = dec_err;
      rsp_rdata_d = (req_write_i || dec_err) ? 32'd0 : rdata;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = 32'd0;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      msip_q      <= '0;
      mtimecmp_q  <= '1;
      mtime_q     <= '0;
      ps_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      mtime_q     <= mtime_d;
      ps_q        <= ps_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Timer interrupts compare registered values only
  always_comb begin
    for (int unsigned i = 0; i < NrCores; i++) begin
      mtip_o[i] = (mtime_q >= mtimecmp_q[i]);
    end
  end

  assign msip_o      = msip_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_error_o = rsp_error_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_cluster_clint.sv
// Randomised bench for cluster_clint with a cycle-stepped reference model and
// a response scoreboard.
module tb_cluster_clint;

  localparam int unsigned NCores = 8;
  localparam int unsigned Psc    = 4;

  logic              clk;
  logic              rst_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [15:0]       req_addr_i;
  logic              req_write_i;
  logic [31:0]       req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_error_o;
  logic [NCores-1:0] msip_o;
  logic [NCores-1:0] mtip_o;

  cluster_clint #(
    .NrCores  (NCores),
    .AddrWidth(16),
    .Prescaler(Psc)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o),
    .msip_o     (msip_o),
    .mtip_o     (mtip_o)
  );

  int checks = 0;
  int errors = 0;
  logic stall = 1'b0;

  // Reference model state
  logic [63:0]       m_mtime;
  logic [63:0]       m_cmp[NCores];
  logic [NCores-1:0] m_msip;
  logic              m_pending;
  longint unsigned   cyc;
  logic [32:0]       exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCores-1:0] exp_mtip();
    logic [NCores-1:0] v;
    for (int i = 0; i < NCores; i++) v[i] = (m_mtime >= m_cmp[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_mtime   = '0;
    m_msip    = '0;
    m_pending = 1'b0;
    cyc       = 0;
    exp_q.delete();
    for (int i = 0; i < NCores; i++) m_cmp[i] = '1;
  endtask

  // Apply one accepted access to the model using the address map rules
  task automatic model_access(input logic [15:0] a, input logic w, input logic [31:0] d,
                              output logic err, output logic [31:0] rd, output logic tload);
    int unsigned ai;
    int unsigned h;
    ai    = a;
    err   = 1'b0;
    rd    = '0;
    tload = 1'b0;
    if (ai % 4 != 0) begin
      err = 1'b1;
    end else if (ai < 'h4000) begin
      h = ai / 4;
      if (h >= NCores) err = 1'b1;
      else if (w) m_msip[h] = d[0];
      else rd = {31'd0, m_msip[h]};
    end else if (ai < 'hBFF8) begin
      h = (ai - 'h4000) / 8;
      if (h >= NCores) err = 1'b1;
      else if (ai % 8 == 4) begin
        if (w) m_cmp[h][63:32] = d; else rd = m_cmp[h][63:32];
      end else begin
        if (w) m_cmp[h][31:0] = d; else rd = m_cmp[h][31:0];
      end
    end else if (ai == 'hBFF8) begin
      if (w) begin m_mtime[31:0] = d; tload = 1'b1; end else rd = m_mtime[31:0];
    end else if (ai == 'hBFFC) begin
      if (w) begin m_mtime[63:32] = d; tload = 1'b1; end else rd = m_mtime[63:32];
    end else begin
      err = 1'b1;
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor + model: compare at falling edge, then advance model for next rising edge
  initial begin
    logic err, tload;
    logic [31:0] rd;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        model_reset();
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_msip", msip_o, 0);
        chk("rst_mtip", mtip_o, 0);
      end else begin
        chk("req_ready", req_ready_o, !m_pending);
        chk("rsp_valid", rsp_valid_o, m_pending);
        if (m_pending && rsp_valid_o && exp_q.size() > 0) begin
          chk("rsp_error", rsp_error_o, exp_q[0][32]);
          chk("rsp_rdata", rsp_rdata_o, exp_q[0][31:0]);
        end
        chk("msip", msip_o, m_msip);
        chk("mtip", mtip_o, exp_mtip());
        tload = 1'b0;
        if (m_pending && rsp_ready_i) begin
          m_pending = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (!m_pending && req_valid_i) begin
          model_access(req_addr_i, req_write_i, req_wdata_i, err, rd, tload);
          exp_q.push_back({err, rd});
          m_pending = 1'b1;
        end
        if (!tload && ((cyc % Psc) == Psc - 1)) m_mtime = m_mtime + 64'd1;
        cyc++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [15:0] a, input logic w, input logic [31:0] d);
    int   n;
    logic acc;
    n           = 0;
    acc         = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_write_i = w;
    req_wdata_i = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("req_accept_timeout", 0, 1);
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_pending && n < 100) begin
      idle(1);
      n++;
    end
    if (m_pending) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int n;
    logic [15:0] a;
    logic [31:0] d;
    int unsigned h;
    logic [15:0] bad_addr[3];
    bad_addr[0] = 16'h0020;
    bad_addr[1] = 16'h0002;
    bad_addr[2] = 16'h8000;

    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Software interrupt for hart 2
    do_req(16'h0008, 1'b1, 32'd1);
    chk("msip_hart2", msip_o, 8'h04);
    do_req(16'h0008, 1'b0, 32'd0);

    // Prescaled mtime after 40 cycles from reset
    drain();
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    idle(40);
    do_req(16'hBFF8, 1'b0, 32'd0);

    // mtimecmp[3] = 100
    do_req(16'h4018, 1'b1, 32'd100);
    do_req(16'h401C, 1'b1, 32'd0);
    n = 0;
    while (!mtip_o[3] && n < 1000) begin
      idle(1);
      n++;
    end
    chk("mtip3_rise", mtip_o[3], 1);
    chk("mtip_only3", mtip_o, 8'h08);
    do_req(16'h401C, 1'b1, 32'hFFFF_FFFF);
    chk("mtip3_clear", mtip_o[3], 0);

    // mtime wrap from all ones
    do_req(16'hBFFC, 1'b1, 32'hFFFF_FFFF);
    do_req(16'hBFF8, 1'b1, 32'hFFFF_FFFF);
    idle(6);
    chk("mtip_after_wrap", mtip_o, 0);
    do_req(16'hBFFC, 1'b0, 32'd0);

    // Error responses held under back-pressure
    for (int k = 0; k < 3; k++) begin
      drain();
      stall = 1'b1;
      idle(1);
      do_req(bad_addr[k], 1'b0, 32'd0);
      idle(5);
      chk("stall_ready", req_ready_o, 0);
      chk("stall_error", rsp_error_o, 1);
      stall = 1'b0;
      idle(1);
    end

    // Reset in the middle of a pending response
    drain();
    for (int k = 0; k < NCores; k++) do_req(16'(4 * k), 1'b1, 32'd1);
    do_req(16'hBFFC, 1'b1, 32'd0);
    do_req(16'hBFF8, 1'b1, 32'd500);
    drain();
    stall = 1'b1;
    idle(1);
    do_req(16'hBFF8, 1'b0, 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rsp_valid", rsp_valid_o, 0);
    chk("async_req_ready", req_ready_o, 1);
    chk("async_msip", msip_o, 0);
    chk("async_mtip", mtip_o, 0);
    chk("async_rdata", rsp_rdata_o, 0);
    chk("async_error", rsp_error_o, 0);
    idle(2);
    rst_ni = 1'b1;
    stall  = 1'b0;
    idle(5);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      h = $urandom_range(0, NCores + 1);
      case ($urandom_range(0, 7))
        0, 1:    a = 16'(4 * h);
        2, 3:    a = 16'(32'h4000 + 8 * h + 4 * $urandom_range(0, 1));
        4:       a = 16'(32'hBFF8 + 4 * $urandom_range(0, 1));
        5:       a = 16'($urandom_range(0, 65535));
        6:       a = 16'(4 * h + $urandom_range(1, 3));
        default: a = 16'h8000;
      endcase
      case ($urandom_range(0, 2))
        0:       d = $urandom;
        1:       d = m_mtime[31:0] + $urandom_range(0, 60);
        default: d = m_mtime[63:32];
      endcase
      do_req(a, 1'($urandom_range(0, 1)), d);
      idle($urandom_range(0, 2));
    end
    drain();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
